// File: rtl/systolic_skew_feeder_pkg.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder_pkg
// Shared systolic definitions for the left-edge setup stages:
//   - SYS_DATA_SIZE / SYS_MAC_WIDTH : default element width and array dimension
//   - feed_state_e                  : streaming FSM state encoding
//   - elem_idx()                    : flat element index (c*MAC_WIDTH+r) of
//                                     element (r,c) inside a packed tile
// -----------------------------------------------------------------------------
package systolic_skew_feeder_pkg;

    localparam int SYS_DATA_SIZE = 8;
    localparam int SYS_MAC_WIDTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } feed_state_e;

    // Tiles are packed column-major: element (row,col) sits at index col*W+row.
    function automatic int elem_idx(input int row, input int col, input int mac_width);
        return (col * mac_width) + row;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_tile_bank_pair.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder_tile_bank_pair
// Two-entry tile store feeding the skew datapath in acceptance order.
// Ports:
//   i_clock        rising-edge clock
//   i_reset        synchronous active-low reset
//   i_tile_in      packed tile to capture
//   i_tile_valid   tile presented
//   i_transpose    transpose flag captured with the tile
//   i_release      streaming tile finishes (last step) at this edge
//   o_tile_ready   a tile can be accepted at this edge
//   o_accept       a tile is accepted at this edge
//   o_rd_tile      tile currently at the head of the store
//   o_rd_transpose transpose flag of the head tile
//   o_count_next   number of tiles held after this edge
// -----------------------------------------------------------------------------
module systolic_skew_feeder_tile_bank_pair
    import systolic_skew_feeder_pkg::*;
#(
    parameter int DATA_SIZE = SYS_DATA_SIZE,
    parameter int MAC_WIDTH = SYS_MAC_WIDTH
) (
    input  logic                                     i_clock,
    input  logic                                     i_reset,
    input  logic [DATA_SIZE*MAC_WIDTH*MAC_WIDTH-1:0] i_tile_in,
    input  logic                                     i_tile_valid,
    input  logic                                     i_transpose,
    input  logic                                     i_release,
    output logic                                     o_tile_ready,
    output logic                                     o_accept,
    output logic [DATA_SIZE*MAC_WIDTH*MAC_WIDTH-1:0] o_rd_tile,
    output logic                                     o_rd_transpose,
    output logic [1:0]                               o_count_next
);

    localparam int TILE_W = DATA_SIZE * MAC_WIDTH * MAC_WIDTH;

    logic [TILE_W-1:0] r_tile [2];
    logic [1:0]        r_transpose;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic              w_release;
    logic              w_ready;
    logic              w_accept;
    logic [1:0]        w_count_next;

    // A release only means something while a bank is actually held.
    assign w_release = i_release && (r_count != 2'd0);
    // A full store still accepts when the head tile leaves at the same edge.
    assign w_ready   = i_reset && ((r_count != 2'd2) || w_release);
    assign w_accept  = i_tile_valid && w_ready;

    // Occupancy after this edge.
    always_comb begin
        w_count_next = r_count;
        case ({w_accept, w_release})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Bank capture, pointer advance and occupancy tracking.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_tile[0]   <= '0;
            r_tile[1]   <= '0;
            r_transpose <= 2'b00;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_accept) begin
                r_tile[r_wr_ptr]      <= i_tile_in;
                r_transpose[r_wr_ptr] <= i_transpose;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_release) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
        end
    end

    assign o_tile_ready   = w_ready;
    assign o_accept       = w_accept;
    assign o_rd_tile      = r_tile[r_rd_ptr];
    assign o_rd_transpose = r_transpose[r_rd_ptr];
    assign o_count_next   = w_count_next;

endmodule

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
// Double-buffered left-edge setup stage: accepts a MAC_WIDTH x MAC_WIDTH tile
// and streams it as diagonally skewed lanes (lane r lags lane r-1 by one step),
// optionally transposed, with back-to-back tiles streaming without bubbles.
// Ports:
//   i_clock       rising-edge clock
//   i_reset       synchronous active-low reset
//   i_tile_in     element (r,c) at [(c*MAC_WIDTH+r)*DATA_SIZE +: DATA_SIZE]
//   i_tile_valid  tile and transpose flag presented
//   i_transpose   1 = feed columns instead of rows
//   o_tile_ready  tile accepted at this edge if valid (combinational)
//   o_lane_out    lane r at [r*DATA_SIZE +: DATA_SIZE]
//   o_lane_valid  bit r = lane r carries a real element
//   o_busy        at least one tile held
//   o_tile_done   pulse on a tile's last step
// -----------------------------------------------------------------------------
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int DATA_SIZE = SYS_DATA_SIZE,
    parameter int MAC_WIDTH = SYS_MAC_WIDTH
) (
    input  logic                                     i_clock,
    input  logic                                     i_reset,
    input  logic [DATA_SIZE*MAC_WIDTH*MAC_WIDTH-1:0] i_tile_in,
    input  logic                                     i_tile_valid,
    input  logic                                     i_transpose,
    output logic                                     o_tile_ready,
    output logic [DATA_SIZE*MAC_WIDTH-1:0]           o_lane_out,
    output logic [MAC_WIDTH-1:0]                     o_lane_valid,
    output logic                                     o_busy,
    output logic                                     o_tile_done
);

    localparam int TILE_W    = DATA_SIZE * MAC_WIDTH * MAC_WIDTH;
    localparam int LANE_W    = DATA_SIZE * MAC_WIDTH;
    localparam int NUM_STEPS = (2 * MAC_WIDTH) - 1;
    localparam int STEP_W    = $clog2(NUM_STEPS);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    feed_state_e        r_state;
    logic [STEP_W-1:0]  r_step;
    logic [LANE_W-1:0]  r_lane;
    logic [MAC_WIDTH-1:0] r_lane_valid;
    logic               r_tile_done;
    logic               r_busy;

    logic               w_release;
    logic               w_accept;
    logic [TILE_W-1:0]  w_rd_tile;
    logic               w_rd_transpose;
    logic [1:0]         w_count_next;
    logic [LANE_W-1:0]  w_lane;
    logic [MAC_WIDTH-1:0] w_lane_valid;

    // The edge that drives the last step also frees the head bank.
    assign w_release = (r_state == ST_STREAM) && (r_step == STEP_LAST);

    systolic_skew_feeder_tile_bank_pair #(
        .DATA_SIZE (DATA_SIZE),
        .MAC_WIDTH (MAC_WIDTH)
    ) u_banks (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_tile_in      (i_tile_in),
        .i_tile_valid   (i_tile_valid),
        .i_transpose    (i_transpose),
        .i_release      (w_release),
        .o_tile_ready   (o_tile_ready),
        .o_accept       (w_accept),
        .o_rd_tile      (w_rd_tile),
        .o_rd_transpose (w_rd_transpose),
        .o_count_next   (w_count_next)
    );

    // Skew select: lane r shows element k = step - r of its row (or column).
    always_comb begin
        w_lane       = '0;
        w_lane_valid = '0;
        for (int r = 0; r < MAC_WIDTH; r++) begin
            if ((int'(r_step) >= r) && ((int'(r_step) - r) < MAC_WIDTH)) begin
                w_lane_valid[r] = 1'b1;
                if (w_rd_transpose) begin
                    w_lane[r*DATA_SIZE +: DATA_SIZE] =
                        w_rd_tile[elem_idx(int'(r_step) - r, r, MAC_WIDTH)*DATA_SIZE +: DATA_SIZE];
                end else begin
                    w_lane[r*DATA_SIZE +: DATA_SIZE] =
                        w_rd_tile[elem_idx(r, int'(r_step) - r, MAC_WIDTH)*DATA_SIZE +: DATA_SIZE];
                end
            end else begin
                w_lane_valid[r] = 1'b0;
            end
        end
    end

    // Streaming FSM with registered lane, valid, done and busy outputs.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_step       <= '0;
            r_lane       <= '0;
            r_lane_valid <= '0;
            r_tile_done  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy <= (w_count_next != 2'd0);
            case (r_state)
                ST_IDLE: begin
                    r_lane       <= '0;
                    r_lane_valid <= '0;
                    r_tile_done  <= 1'b0;
                    r_step       <= '0;
                    if (w_accept) begin
                        r_state <= ST_STREAM;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    r_lane       <= w_lane;
                    r_lane_valid <= w_lane_valid;
                    r_tile_done  <= w_release;
                    if (w_release) begin
                        // Any tile still held (incl. one accepted now) starts at once.
                        r_step  <= '0;
                        r_state <= (w_count_next != 2'd0) ? ST_STREAM : ST_IDLE;
                    end else begin
                        r_step  <= r_step + STEP_ONE;
                        r_state <= ST_STREAM;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_step       <= '0;
                    r_lane       <= '0;
                    r_lane_valid <= '0;
                    r_tile_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_lane_out   = r_lane;
    assign o_lane_valid = r_lane_valid;
    assign o_tile_done  = r_tile_done;
    assign o_busy       = r_busy;

endmodule
